disassemble_pack: RTL and testbench

//  Receive-side counterpart of the 176-bit game-state packet assembler.
//  - Consumes a byte-serial stream, hunts for the 0x55AA sync word and collects the 20 payload bytes.
//  - Presents player position plus three wave rows (y + 40-bit bitfield) as registered fields.
//  - Sits between the byte link receiver and the display/game logic.

---
 rtl/disassemble_pkg.sv | 52 +++++
 rtl/disassemble_pack_sync_hunt.sv | 48 ++++
 rtl/disassemble_pack.sv | 126 ++++++++++++
 tb/tb_disassemble_pack.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/disassemble_pkg.sv
// Shared constants, state encoding and frame layout for the game-state packet receiver.
package disassemble_pkg;

   localparam logic [7:0] SYNC_LO       = 8'hAA;
   localparam logic [7:0] SYNC_HI       = 8'h55;
   localparam int         PAYLOAD_BYTES = 20;
   localparam int         PACKET_W      = 176;
   localparam int         STAGE_W       = PAYLOAD_BYTES * 8;
   localparam int         CNT_W         = $clog2(PAYLOAD_BYTES);

   // Byte offsets of each field within the payload (b2 on the wire is offset 0)
   localparam int OFF_PX   = 0;
   localparam int OFF_PY   = 1;
   localparam int OFF_W1Y  = 2;
   localparam int OFF_W1BF = 3;
   localparam int OFF_W2Y  = 8;
   localparam int OFF_W2BF = 9;
   localparam int OFF_W3Y  = 14;
   localparam int OFF_W3BF = 15;

   typedef enum logic [1:0] {
      HUNT_LO = 2'd0,
      HUNT_HI = 2'd1,
      PAYLOAD = 2'd2
   } state_e;

   typedef struct packed {
      logic [7:0]  px;
      logic [7:0]  py;
      logic [7:0]  w1y;
      logic [39:0] w1bf;
      logic [7:0]  w2y;
      logic [39:0] w2bf;
      logic [7:0]  w3y;
      logic [39:0] w3bf;
   } frame_t;

   // Payload byte 0 sits in the low byte of the staging vector.
   function automatic frame_t unpack_frame(input logic [STAGE_W-1:0] s);
      frame_t f;
      f.px   = s[OFF_PX*8   +: 8];
      f.py   = s[OFF_PY*8   +: 8];
      f.w1y  = s[OFF_W1Y*8  +: 8];
      f.w1bf = s[OFF_W1BF*8 +: 40];
      f.w2y  = s[OFF_W2Y*8  +: 8];
      f.w2bf = s[OFF_W2BF*8 +: 40];
      f.w3y  = s[OFF_W3Y*8  +: 8];
      f.w3bf = s[OFF_W3BF*8 +: 40];
      return f;
   endfunction

endpackage

// File: rtl/disassemble_pack_sync_hunt.sv
// Receive state machine: hunts for the AA 55 sync word, pulses sync_found_o and
// holds PAYLOAD until the top reports the last byte or an inter-byte timeout.
module pack_sync_hunt
   import disassemble_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data_i,
   input  logic       rx_valid_i,
   input  logic       frame_done_i,
   input  logic       abort_i,
   output state_e     state_o,
   output logic       sync_found_o
);

   state_e state_q, state_d;

   always_comb begin
      state_d      = state_q;
      sync_found_o = 1'b0;
      if (rx_valid_i) begin
         unique case (state_q)
            HUNT_LO: if (rx_data_i == SYNC_LO) state_d = HUNT_HI;
            HUNT_HI: begin
               if (rx_data_i == SYNC_HI) begin
                  state_d      = PAYLOAD;
                  sync_found_o = 1'b1;
               end else if (rx_data_i != SYNC_LO) begin
                  state_d = HUNT_LO;
               end
            end
            // payload bytes are data only, never re-examined for sync
            PAYLOAD: if (frame_done_i) state_d = HUNT_LO;
            default: state_d = HUNT_LO;
         endcase
      end else if (abort_i) begin
         state_d = HUNT_LO;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= HUNT_LO;
      else        state_q <= state_d;
   end

   assign state_o = state_q;

endmodule

// File: rtl/disassemble_pack.sv
// Byte-serial game-state packet receiver: sync hunt, 20-byte payload staging, registered fields.
// Optional inter-byte timeout enabled by defining DISASSEMBLE_TIMEOUT_EN.
module disassemble_pack
   import disassemble_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  player_x,
   output logic [7:0]  player_y,
   output logic [7:0]  wave1_y,
   output logic [7:0]  wave2_y,
   output logic [7:0]  wave3_y,
   output logic [39:0] wave1_bitfield,
   output logic [39:0] wave2_bitfield,
   output logic [39:0] wave3_bitfield,
   output logic        frame_valid,
   output logic        busy,
   output logic        timeout_err
);

   state_e             state;
   logic               sync_found;
   logic               in_payload;
   logic               last_byte;
   logic               abort;

   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [STAGE_W-1:0] stage_q, stage_d;
   frame_t             frame_q, frame_d;
   logic               fv_q,    fv_d;

   pack_sync_hunt u_hunt (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_data_i    (rx_data),
      .rx_valid_i   (rx_valid),
      .frame_done_i (last_byte),
      .abort_i      (abort),
      .state_o      (state),
      .sync_found_o (sync_found)
   );

   assign in_payload = (state == PAYLOAD);
   assign last_byte  = rx_valid && in_payload && (cnt_q == CNT_W'(PAYLOAD_BYTES-1));
   assign busy       = (state != HUNT_LO);

   // Bytes enter at the top, so after 20 shifts payload byte 0 lands in the low byte.
   always_comb begin
      cnt_d   = cnt_q;
      stage_d = stage_q;
      frame_d = frame_q;
      fv_d    = 1'b0;
      if (sync_found) begin
         cnt_d = '0;
      end else if (rx_valid && in_payload) begin
         stage_d = {rx_data, stage_q[STAGE_W-1:8]};
         cnt_d   = cnt_q + CNT_W'(1);
         if (last_byte) begin
            frame_d = unpack_frame(stage_d);
            fv_d    = 1'b1;
            cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         stage_q <= '0;
         frame_q <= '0;
         fv_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         frame_q <= frame_d;
         fv_q    <= fv_d;
      end
   end

`ifdef DISASSEMBLE_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              to_q;

   // A byte in the timeout cycle keeps the frame alive, since abort requires an idle cycle.
   assign abort = !rx_valid && busy && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      idle_d = idle_q + IDLE_W'(1);
      if (rx_valid || !busy || abort) idle_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_q <= '0;
         to_q   <= 1'b0;
      end else begin
         idle_q <= idle_d;
         to_q   <= abort;
      end
   end

   assign timeout_err = to_q;
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TIMEOUT_CYCLES);
   assign abort          = 1'b0;
   assign timeout_err    = 1'b0;
`endif

   assign player_x       = frame_q.px;
   assign player_y       = frame_q.py;
   assign wave1_y        = frame_q.w1y;
   assign wave2_y        = frame_q.w2y;
   assign wave3_y        = frame_q.w3y;
   assign wave1_bitfield = frame_q.w1bf;
   assign wave2_bitfield = frame_q.w2bf;
   assign wave3_bitfield = frame_q.w3bf;
   assign frame_valid    = fv_q;

endmodule

// File: tb/tb_disassemble_pack.sv
// Directed bench for disassemble_pack: table of payloads with hand-computed fields plus corner sequences.
module tb_disassemble_pack;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  player_x, player_y, wave1_y, wave2_y, wave3_y;
   logic [39:0] wave1_bitfield, wave2_bitfield, wave3_bitfield;
   logic        frame_valid, busy, timeout_err;

   disassemble_pack #(.TIMEOUT_CYCLES(1024)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .player_x       (player_x),
      .player_y       (player_y),
      .wave1_y        (wave1_y),
      .wave2_y        (wave2_y),
      .wave3_y        (wave3_y),
      .wave1_bitfield (wave1_bitfield),
      .wave2_bitfield (wave2_bitfield),
      .wave3_bitfield (wave3_bitfield),
      .frame_valid    (frame_valid),
      .busy           (busy),
      .timeout_err    (timeout_err)
   );

   always #5 clk = ~clk;

   // pl holds the 20 payload bytes in wire order, first byte in the top 8 bits
   typedef struct {
      string        nm;
      logic [159:0] pl;
      logic [7:0]   px, py, w1y, w2y, w3y;
      logic [39:0]  w1, w2, w3;
   } vec_t;

   vec_t vt[5];

   int n_tests = 0;
   int n_fail  = 0;
   int pulse_cnt = 0;
   int to_cnt    = 0;
   logic [159:0] cap_q[$];
   bit           mon_en = 0;
   bit           mon_first = 1;
   logic [159:0] prev_cat;
   int           stab_err = 0;

   function automatic logic [159:0] dut_cat();
      return {player_x, player_y, wave1_y, wave1_bitfield, wave2_y, wave2_bitfield,
              wave3_y, wave3_bitfield};
   endfunction

   function automatic logic [159:0] exp_cat(input vec_t v);
      return {v.px, v.py, v.w1y, v.w1, v.w2y, v.w2, v.w3y, v.w3};
   endfunction

   always @(negedge clk) begin
      if (frame_valid) begin
         pulse_cnt++;
         cap_q.push_back(dut_cat());
      end
      if (timeout_err) to_cnt++;
      if (mon_en) begin
         if (!mon_first && !frame_valid && dut_cat() !== prev_cat) stab_err++;
         mon_first = 0;
         prev_cat  = dut_cat();
      end
   end

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_payload(input vec_t v, input int first, input int last, input bit bub);
      logic [159:0] p;
      p = v.pl;
      for (int i = first; i <= last; i++) begin
         if (bub) idle($urandom_range(0, 2));
         send(p[159-8*i -: 8]);
      end
   endtask

   task automatic send_frame(input vec_t v, input bit bub);
      send(8'hAA);
      send(8'h55);
      send_payload(v, 0, 19, bub);
   endtask

   task automatic check_fields(input string tag, input vec_t v);
      chk({tag, ".px"},  {152'h0, player_x},       {152'h0, v.px});
      chk({tag, ".py"},  {152'h0, player_y},       {152'h0, v.py});
      chk({tag, ".w1y"}, {152'h0, wave1_y},        {152'h0, v.w1y});
      chk({tag, ".w1"},  {120'h0, wave1_bitfield}, {120'h0, v.w1});
      chk({tag, ".w2y"}, {152'h0, wave2_y},        {152'h0, v.w2y});
      chk({tag, ".w2"},  {120'h0, wave2_bitfield}, {120'h0, v.w2});
      chk({tag, ".w3y"}, {152'h0, wave3_y},        {152'h0, v.w3y});
      chk({tag, ".w3"},  {120'h0, wave3_bitfield}, {120'h0, v.w3});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, t0;

      vt[0] = '{"clean", 160'h1020300102030405401112131415502122232425,
                8'h10, 8'h20, 8'h30, 8'h40, 8'h50,
                40'h0504030201, 40'h1514131211, 40'h2524232221};
      vt[1] = '{"syncdata", 160'hAA55AA55AA55AA55AA55AA55AA55AA55AA55AA55,
                8'hAA, 8'h55, 8'hAA, 8'hAA, 8'hAA,
                40'h55AA55AA55, 40'h55AA55AA55, 40'h55AA55AA55};
      vt[2] = '{"ones", {160{1'b1}},
                8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF};
      vt[3] = '{"ramp", 160'h0102030405060708090A0B0C0D0E0F1011121314,
                8'h01, 8'h02, 8'h03, 8'h09, 8'h0F,
                40'h0807060504, 40'h0E0D0C0B0A, 40'h1413121110};
      vt[4] = '{"zerotop", 160'h0000000000000000000000000000000000000080,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                40'h0000000000, 40'h0000000000, 40'h8000000000};

      // Reset with random traffic
      rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         rx_data  = 8'($urandom);
         rx_valid = 1'($urandom_range(0, 1));
         idle(1);
      end
      chk("rst.fields", dut_cat(), 160'h0);
      chk("rst.busy", {159'h0, busy}, 160'h0);
      chk("rst.fv", {159'h0, frame_valid}, 160'h0);
      chk("rst.to", {159'h0, timeout_err}, 160'h0);
      rx_valid = 1'b0;
      rst_n    = 1'b1;
      idle(2);

      // Table of clean frames
      foreach (vt[i]) begin
         p0 = pulse_cnt;
         send(8'hAA);
         send(8'h55);
         send_payload(vt[i], 0, 18, 0);
         chk({vt[i].nm, ".busy"}, {159'h0, busy}, {159'h0, 1'b1});
         send_payload(vt[i], 19, 19, 0);
         chk({vt[i].nm, ".fv_lat"}, {159'h0, frame_valid}, {159'h0, 1'b1});
         chk({vt[i].nm, ".idle"}, {159'h0, busy}, 160'h0);
         check_fields(vt[i].nm, vt[i]);
         idle(1);
         chk({vt[i].nm, ".fv_drop"}, {159'h0, frame_valid}, 160'h0);
         chk({vt[i].nm, ".pulses"}, 160'(pulse_cnt - p0), 160'd1);
      end

      // Resync through false starts
      p0 = pulse_cnt;
      send(8'h00); send(8'hAA); send(8'h13); send(8'hAA); send(8'hAA); send(8'h55);
      send_payload(vt[3], 0, 19, 0);
      idle(2);
      chk("resync.pulses", 160'(pulse_cnt - p0), 160'd1);
      check_fields("resync", vt[3]);

      // Bubbles plus back-to-back frames
      cap_q.delete();
      mon_first = 1; stab_err = 0; mon_en = 1;
      p0 = pulse_cnt;
      send_frame(vt[1], 1);
      send_frame(vt[2], 1);
      idle(4);
      mon_en = 0;
      chk("b2b.pulses", 160'(pulse_cnt - p0), 160'd2);
      chk("b2b.qsize", 160'(cap_q.size()), 160'd2);
      if (cap_q.size() >= 2) begin
         chk("b2b.frame0", cap_q[0], exp_cat(vt[1]));
         chk("b2b.frame1", cap_q[1], exp_cat(vt[2]));
      end
      chk("b2b.stable", 160'(stab_err), 160'd0);

      // Reset after 10 payload bytes
      send(8'hAA); send(8'h55);
      send_payload(vt[3], 0, 9, 0);
      chk("midrst.busy_pre", {159'h0, busy}, {159'h0, 1'b1});
      rst_n = 1'b0;
      idle(1);
      chk("midrst.fields", dut_cat(), 160'h0);
      chk("midrst.busy", {159'h0, busy}, 160'h0);
      rst_n = 1'b1;
      idle(1);
      p0 = pulse_cnt;
      send_frame(vt[0], 0);
      idle(2);
      chk("midrst.pulses", 160'(pulse_cnt - p0), 160'd1);
      check_fields("midrst", vt[0]);

      // Long stall mid-payload
      p0 = pulse_cnt; t0 = to_cnt;
      send(8'hAA); send(8'h55);
      send_payload(vt[3], 0, 9, 0);
      idle(1030);
`ifdef DISASSEMBLE_TIMEOUT_EN
      chk("stall.to_pulse", 160'(to_cnt - t0), 160'd1);
      chk("stall.busy", {159'h0, busy}, 160'h0);
      check_fields("stall.hold", vt[0]);
      send_payload(vt[3], 10, 19, 0);
      idle(2);
      chk("stall.pulses", 160'(pulse_cnt - p0), 160'd0);
      check_fields("stall.after", vt[0]);
`else
      chk("stall.busy", {159'h0, busy}, {159'h0, 1'b1});
      send_payload(vt[3], 10, 19, 0);
      idle(2);
      chk("stall.pulses", 160'(pulse_cnt - p0), 160'd1);
      chk("stall.to_pulse", 160'(to_cnt - t0), 160'd0);
      check_fields("stall.after", vt[3]);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
